// File: rtl/position_stepper_if.sv
// Target handshake, position feedback and step-pulse bundle for position_stepper.
interface position_stepper_if;
  logic       tgt_valid;
  logic [7:0] tgt_pos;
  logic       tgt_ready;
  logic [7:0] pos;
  logic       abort;
  logic       cnt_up;
  logic       cnt_down;
  logic       busy;
  logic       done;

  modport master (
    output tgt_valid, tgt_pos, pos, abort,
    input  tgt_ready, cnt_up, cnt_down, busy, done
  );

  modport slave (
    input  tgt_valid, tgt_pos, pos, abort,
    output tgt_ready, cnt_up, cnt_down, busy, done
  );
endinterface

// File: rtl/position_stepper.sv
// Closed-loop stepper: compares fed-back position with a latched target and issues
// single-cycle up/down pulses spaced STEP_PERIOD+1 clocks apart until they match.
module position_stepper #(
  parameter int unsigned STEP_PERIOD = 50000
) (
  input  logic                clk,
  input  logic                rst,
  position_stepper_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  target_q, target_d;
  logic        up_q, up_d;
  logic        down_q, down_d;
  logic        done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      target_q <= '0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      target_q <= target_d;
      up_q     <= up_d;
      down_q   <= down_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    target_d = target_q;
    up_d     = 1'b0;
    down_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.tgt_valid && !bus.abort) begin
          target_d = bus.tgt_pos;
          state_d  = MOVE;
        end
      end
      MOVE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.pos < target_q) begin
          up_d    = 1'b1;
          timer_d = 16'(STEP_PERIOD - 1);
          state_d = WAIT;
        end else if (bus.pos > target_q) begin
          down_d  = 1'b1;
          timer_d = 16'(STEP_PERIOD - 1);
          state_d = WAIT;
        end else begin
          state_d = DONE;
        end
      end
      WAIT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          state_d = MOVE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      DONE: begin
        // done is registered off DONE, so the pulse lands the cycle after DONE.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tgt_ready = (state_q == IDLE) && !rst;
  assign bus.busy      = (state_q != IDLE) && !rst;
  assign bus.done      = done_q;
  assign bus.cnt_up    = up_q;
  assign bus.cnt_down  = down_q;

endmodule

// File: tb/tb_position_stepper.sv
// Directed bench for position_stepper (STEP_PERIOD=4) with a behavioural 8-bit
// up/down counter closing the position loop.
module tb_position_stepper;

  logic clk = 1'b0;
  logic rst;
  position_stepper_if bus();

  logic       preset_en;
  logic [7:0] preset_val;
  logic [7:0] cnt_pos;

  int n_checks = 0;
  int n_fail   = 0;

  // results of the last do_move
  int pk[$];
  int n_up, n_down, n_done, done_k, busy_cnt, overlap, post_pulses;

  position_stepper #(.STEP_PERIOD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preset_en)         cnt_pos <= preset_val;
    else if (bus.cnt_up)   cnt_pos <= cnt_pos + 8'd1;
    else if (bus.cnt_down) cnt_pos <= cnt_pos - 8'd1;
  end

  assign bus.pos = cnt_pos;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preset(input logic [7:0] v);
    preset_en  = 1'b1;
    preset_val = v;
    tick();
    preset_en  = 1'b0;
  endtask

  // Accept target t at the next edge (E), then observe from cycle k=0 (after E)
  // until six cycles past done or until the budget runs out.
  task automatic do_move(input logic [7:0] t, input int budget);
    bus.tgt_valid = 1'b1;
    bus.tgt_pos   = t;
    tick();
    bus.tgt_valid = 1'b0;
    bus.tgt_pos   = ~t;
    pk.delete();
    n_up = 0; n_down = 0; n_done = 0; done_k = -1;
    busy_cnt = 0; overlap = 0; post_pulses = 0;
    for (int k = 0; k < budget; k++) begin
      if (bus.cnt_up || bus.cnt_down) begin
        pk.push_back(k);
        if (done_k >= 0) post_pulses++;
      end
      if (bus.cnt_up)                 n_up++;
      if (bus.cnt_down)               n_down++;
      if (bus.cnt_up && bus.cnt_down) overlap++;
      if (bus.busy)                   busy_cnt++;
      if (bus.done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k >= done_k + 6) break;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.tgt_valid = 1'b0;
    bus.tgt_pos   = '0;
    bus.abort     = 1'b0;
    preset_en     = 1'b0;
    preset_val    = '0;
    tick();
    preset(8'd128);
    tick();
    n_checks++;
    if ({bus.tgt_ready, bus.busy, bus.done, bus.cnt_up, bus.cnt_down} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected 00000",
               {bus.tgt_ready, bus.busy, bus.done, bus.cnt_up, bus.cnt_down});
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.tgt_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, expected 1", bus.tgt_ready);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_busy: got %b, expected 0", bus.busy);
    end
  endtask

  task automatic test_move_up();
    preset(8'd128);
    do_move(8'd131, 60);
    n_checks++;
    if (n_up !== 3) begin
      n_fail++; $display("FAIL up_count: got %0d, expected 3", n_up);
    end
    n_checks++;
    if (n_down !== 0) begin
      n_fail++; $display("FAIL up_no_down: got %0d, expected 0", n_down);
    end
    n_checks++;
    if (pk.size() != 3 || pk[0] != 1 || pk[1] != 6 || pk[2] != 11) begin
      n_fail++;
      $display("FAIL up_spacing: got %0d pulses first at %0d, expected cycles 1,6,11",
               pk.size(), (pk.size() > 0) ? pk[0] : -1);
    end
    n_checks++;
    if (done_k !== 17 || n_done !== 1) begin
      n_fail++;
      $display("FAIL up_done: got cycle %0d count %0d, expected cycle 17 count 1", done_k, n_done);
    end
    n_checks++;
    if (cnt_pos !== 8'd131) begin
      n_fail++; $display("FAIL up_pos: got %0d, expected 131", cnt_pos);
    end
    n_checks++;
    if (bus.tgt_ready !== 1'b1) begin
      n_fail++; $display("FAIL up_ready: got %b, expected 1", bus.tgt_ready);
    end
    n_checks++;
    if (overlap !== 0) begin
      n_fail++; $display("FAIL up_overlap: got %0d, expected 0", overlap);
    end
  endtask

  task automatic test_move_down_floor();
    preset(8'd2);
    do_move(8'd0, 60);
    n_checks++;
    if (n_down !== 2 || n_up !== 0) begin
      n_fail++; $display("FAIL floor_count: got down %0d up %0d, expected down 2 up 0", n_down, n_up);
    end
    n_checks++;
    if (done_k !== 12) begin
      n_fail++; $display("FAIL floor_done: got cycle %0d, expected 12", done_k);
    end
    n_checks++;
    if (cnt_pos !== 8'd0) begin
      n_fail++; $display("FAIL floor_pos: got %0d, expected 0", cnt_pos);
    end
    n_checks++;
    if (post_pulses !== 0) begin
      n_fail++; $display("FAIL floor_after_done: got %0d pulses, expected 0", post_pulses);
    end
  endtask

  task automatic test_null_move();
    preset(8'd128);
    do_move(8'd128, 20);
    n_checks++;
    if (n_up + n_down !== 0) begin
      n_fail++; $display("FAIL null_pulses: got %0d, expected 0", n_up + n_down);
    end
    n_checks++;
    if (done_k !== 2) begin
      n_fail++; $display("FAIL null_done: got cycle %0d, expected 2", done_k);
    end
    n_checks++;
    if (busy_cnt !== 2) begin
      n_fail++; $display("FAIL null_busy: got %0d cycles, expected 2", busy_cnt);
    end
  endtask

  task automatic test_abort();
    int np;
    int nd;
    preset(8'd128);
    bus.tgt_valid = 1'b1;
    bus.tgt_pos   = 8'd200;
    tick();
    bus.tgt_valid = 1'b0;
    np = 0;
    for (int k = 0; k < 7; k++) begin
      if (bus.cnt_up) np++;
      tick();
    end
    n_checks++;
    if (np !== 2) begin
      n_fail++; $display("FAIL abort_pre_pulses: got %0d, expected 2", np);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.tgt_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_idle: got busy %b ready %b, expected busy 0 ready 1", bus.busy, bus.tgt_ready);
    end
    np = 0;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.cnt_up || bus.cnt_down) np++;
      if (bus.done) nd++;
      tick();
    end
    n_checks++;
    if (np !== 0 || nd !== 0) begin
      n_fail++; $display("FAIL abort_quiet: got pulses %0d done %0d, expected 0 0", np, nd);
    end
    n_checks++;
    if (cnt_pos !== 8'd130) begin
      n_fail++; $display("FAIL abort_pos: got %0d, expected 130", cnt_pos);
    end
  endtask

  task automatic test_reset_mid_wait();
    preset(8'd128);
    bus.tgt_valid = 1'b1;
    bus.tgt_pos   = 8'd140;
    tick();
    bus.tgt_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.cnt_up !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_first_pulse: got %b, expected 1", bus.cnt_up);
    end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({bus.tgt_ready, bus.busy, bus.done, bus.cnt_up, bus.cnt_down} !== 5'b0) begin
        n_fail++;
        $display("FAIL rstmid_outputs: got %b, expected 00000",
                 {bus.tgt_ready, bus.busy, bus.done, bus.cnt_up, bus.cnt_down});
      end
    end
    rst = 1'b0;
    n_checks++;
    if (cnt_pos !== 8'd129) begin
      n_fail++; $display("FAIL rstmid_pos: got %0d, expected 129", cnt_pos);
    end
    tick();
    n_checks++;
    if (bus.tgt_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_ready: got %b, expected 1", bus.tgt_ready);
    end
    do_move(8'd100, 200);
    n_checks++;
    if (n_down !== 29 || n_up !== 0) begin
      n_fail++; $display("FAIL rstmid_down_count: got down %0d up %0d, expected 29 0", n_down, n_up);
    end
    n_checks++;
    if (done_k !== 147) begin
      n_fail++; $display("FAIL rstmid_done: got cycle %0d, expected 147", done_k);
    end
    n_checks++;
    if (cnt_pos !== 8'd100) begin
      n_fail++; $display("FAIL rstmid_final_pos: got %0d, expected 100", cnt_pos);
    end
  endtask

  task automatic test_abort_vs_valid();
    int nb;
    int np;
    preset(8'd128);
    bus.tgt_valid = 1'b1;
    bus.tgt_pos   = 8'd50;
    bus.abort     = 1'b1;
    tick();
    bus.tgt_valid = 1'b0;
    bus.abort     = 1'b0;
    nb = 0;
    np = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.busy) nb++;
      if (bus.cnt_up || bus.cnt_down) np++;
      tick();
    end
    n_checks++;
    if (nb !== 0) begin
      n_fail++; $display("FAIL race_busy: got %0d busy cycles, expected 0", nb);
    end
    n_checks++;
    if (np !== 0) begin
      n_fail++; $display("FAIL race_pulses: got %0d, expected 0", np);
    end
    n_checks++;
    if (cnt_pos !== 8'd128) begin
      n_fail++; $display("FAIL race_pos: got %0d, expected 128", cnt_pos);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_move_up();
    test_move_down_floor();
    test_null_move();
    test_abort();
    test_reset_mid_wait();
    test_abort_vs_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
